my_spi_tx: RTL
==============

# my_spi_tx

Serial frame transmitter: the sending end of the 11-bit, LSB-first, free-running serial link whose receiver samples `rx` on the falling edge of `clk`. It accepts parallel words over a valid/ready handshake, buffers one word, and shifts frames continuously onto `tx`, one bit per clock. When no word is pending it sends a fixed idle word, so the receiver's bit alignment is never lost. It sits in the sending design, clocked by the same `clk` that is forwarded to the receiver.

## Interface
- `FRAME_BITS`, 11: bits per frame; the receiver is fixed at 11.
- `IDLE_WORD`, 11'h000: word sent when no data word is pending.
- `CNT_BITS`, 6: width of the frame counter.
- `clk`  in  1  link clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  FRAME_BITS  word to transmit.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  the block can accept a word this cycle.
- `tx`  out  1  serial data, registered, LSB first.
- `frame_start`  out  1  high during the cycle in which bit 0 of a frame is on `tx`.
- `frame_is_data`  out  1  the frame now on `tx` carries an accepted word (0 = idle word).
- `frame_count`  out  CNT_BITS  number of completed frames, modulo 2^CNT_BITS.
- `underrun`  out  1  sticky flag: an idle frame was sent after at least one data frame.

## Operation
- **State:**
  - holding register `hold` plus `hold_valid`.
  - shift register `shreg` of FRAME_BITS.
  - bit index `bit_idx` (0..FRAME_BITS-1).
  - `frame_count`.
  - `started` flag.
- **Accept:** a word is accepted on a rising edge where `in_valid && in_ready`. It is written to `hold` and `hold_valid` is set.
- **`in_ready`:** `in_ready` = `!hold_valid`. It is a registered term with no combinational path from `in_valid`.
- **Frame boundary:** this is any edge at which `bit_idx` wraps from FRAME_BITS-1 to 0, plus the first edge after reset.
  - If `hold_valid` = 1: the frame word is `hold`, and `hold_valid` clears.
  - Otherwise: the frame word is `IDLE_WORD`.
  - At the same edge: `tx` ← word[0], `shreg` ← word >> 1, and `frame_is_data` is set accordingly.
- **Mid-frame:** `tx` ← `shreg[0]`, `shreg` ← `shreg` >> 1, `bit_idx` increments.
- **Simultaneous events:**
  - Accept and drain in the same edge cannot happen, because `in_ready` = 0 while `hold` is full.
  - A word accepted at a boundary edge with `hold` empty goes to `hold`, not to the current frame. It is sent in the next frame; there is no bypass path.
- **Frame counter:** `frame_count` increments at every boundary edge except the first edge after reset. It wraps from 2^CNT_BITS-1 to 0.
- **`underrun`:** set when an idle frame starts and at least one data frame has been sent since reset. It is cleared only by reset.
- **Reset:** reset is asynchronous and may arrive mid-frame. It aborts the frame immediately; no partial-frame completion is required.

## Timing
- **Reset values:**
  - `tx` = 0, `in_ready` = 1, `frame_start` = 0, `frame_is_data` = 0.
  - `frame_count` = 0, `underrun` = 0.
  - `hold_valid` = 0, `bit_idx` = 0, `started` = 0.
- **Bit placement:** the first rising edge after `rst_n` deasserts begins frame 0. Bit k of a frame is on `tx` from edge k to edge k+1 of that frame.
- **Sampling margin:** `tx` changes only on rising edges, so the receiver's falling-edge sample lands mid-bit.
- **Latency:** a word accepted at edge A with `hold` empty and mid-frame appears at the next boundary edge. From acceptance to bit 0 takes 1 to FRAME_BITS cycles.
- **Throughput:** one word per FRAME_BITS cycles. This is sustained with back-to-back frames and no gap cycles.
- **`frame_start`:** registered, high for exactly 1 cycle per frame, aligned with bit 0 on `tx`.

## Structure
- **Shared package:** holds `FRAME_BITS`, `CNT_BITS` and `IDLE_WORD`, so the receiver and transmitter use one definition.
- **Sub-module:** one natural sub-module, `tx_hold_buf`: the one-entry valid/ready holding register, with a drain strobe and an output word. The shifter and counters stay in `my_spi_tx`.

## Test plan
- **Reset, no input:** `in_valid` = 0 for 33 cycles after reset.
  - `tx` constantly 0.
  - `frame_start` at cycles 0, 11, 22.
  - `frame_count` = 3 after cycle 33.
  - `frame_is_data` = 0 and `underrun` = 0.
- **Single word:** 11'h5A3 accepted mid-frame 0.
  - Frame 1 `tx` sequence is 1,1,0,0,0,1,0,1,1,0,1 (LSB first).
  - `frame_is_data` = 1 for frame 1, then 0 for frame 2.
  - `underrun` = 1 from the start of frame 2.
- **Back-to-back words:** 11'h7FF, 11'h001, 11'h400 with `in_valid` held high.
  - `in_ready` drops after each accept.
  - The three frames are contiguous and bit-exact.
  - A loopback receiver model, sampling on `negedge clk`, recovers all three words.
- **Counter wrap:** run 64 frames, then 1 more.
  - `frame_count` goes 63 → 0 at the 64th boundary and is 1 after the 65th.
- **Boundary accept:** assert `in_valid` with 11'h2AA exactly at a boundary edge, `hold` empty.
  - The current frame is idle.
  - 11'h2AA is sent in the following frame.
- **Reset mid-frame:** assert `rst_n` = 0 during bit 5 of data frame 11'h3C3.
  - All outputs take their reset values immediately, without a clock edge.
  - After release, frame 0 starts on the first edge and is idle.

Source files
------------

// File: rtl/my_spi_tx_pkg.sv
// my_spi_tx_pkg: link constants shared by the serial transmitter and its receiver.
package my_spi_tx_pkg;
    localparam int FRAME_BITS = 11;
    localparam int CNT_BITS = 6;
    localparam int IDX_BITS = $clog2(FRAME_BITS);
    localparam logic [FRAME_BITS-1:0] IDLE_WORD = '0;
endpackage

// File: rtl/my_spi_tx_hold_buf.sv
// tx_hold_buf: one-entry valid/ready holding register drained by the frame shifter.
module tx_hold_buf
    import my_spi_tx_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FRAME_BITS-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  drain_i,
    output logic [FRAME_BITS-1:0] word_o,
    output logic                  valid_o
);
    logic                  valid_q;
    logic [FRAME_BITS-1:0] word_q;
    // Accept needs an empty entry and drain needs a full one, so they never coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            word_q  <= '0;
        end else if (in_valid && !valid_q) begin
            valid_q <= 1'b1;
            word_q  <= in_data;
        end else if (drain_i) begin
            valid_q <= 1'b0;
        end
    end
    assign in_ready = !valid_q;
    assign word_o   = word_q;
    assign valid_o  = valid_q;
endmodule

// File: rtl/my_spi_tx.sv
// my_spi_tx: free-running LSB-first frame transmitter; sends IDLE_WORD when no word is held.
module my_spi_tx
    import my_spi_tx_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FRAME_BITS-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  tx,
    output logic                  frame_start,
    output logic                  frame_is_data,
    output logic [CNT_BITS-1:0]   frame_count,
    output logic                  underrun
);
    logic                  hold_valid, boundary;
    logic [FRAME_BITS-1:0] hold_word, word_d;
    logic [FRAME_BITS-1:0] shreg_q;
    logic [IDX_BITS-1:0]   bit_idx_q;
    logic [CNT_BITS-1:0]   frame_count_q;
    logic                  tx_q, frame_start_q, frame_is_data_q, underrun_q, started_q, sent_q;

    tx_hold_buf u_hold (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .drain_i  (boundary),
        .word_o   (hold_word),
        .valid_o  (hold_valid)
    );

    // The first edge after reset starts frame 0 without counting a completed frame.
    assign boundary = !started_q || bit_idx_q == IDX_BITS'(FRAME_BITS - 1);
    assign word_d   = hold_valid ? hold_word : IDLE_WORD;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q         <= '0;
            bit_idx_q       <= '0;
            frame_count_q   <= '0;
            tx_q            <= 1'b0;
            frame_start_q   <= 1'b0;
            frame_is_data_q <= 1'b0;
            underrun_q      <= 1'b0;
            started_q       <= 1'b0;
            sent_q          <= 1'b0;
        end else if (boundary) begin
            tx_q            <= word_d[0];
            shreg_q         <= word_d >> 1;
            bit_idx_q       <= '0;
            frame_start_q   <= 1'b1;
            frame_is_data_q <= hold_valid;
            started_q       <= 1'b1;
            sent_q          <= sent_q || hold_valid;
            if (started_q) frame_count_q <= frame_count_q + 1'b1;
            if (!hold_valid && sent_q) underrun_q <= 1'b1;
        end else begin
            tx_q          <= shreg_q[0];
            shreg_q       <= shreg_q >> 1;
            bit_idx_q     <= bit_idx_q + 1'b1;
            frame_start_q <= 1'b0;
        end
    end

    assign tx            = tx_q;
    assign frame_start   = frame_start_q;
    assign frame_is_data = frame_is_data_q;
    assign frame_count   = frame_count_q;
    assign underrun      = underrun_q;
endmodule
